// File: rtl/sample_readback.sv
`default_nettype none
// ============================================================================
// Module   : sample_readback
// Purpose  : Reads a finished capture back out of the sample memory ring
//            buffer and decodes each stored packet into interval, channel data,
//            trigger flag and last flag for the host upload serializer.
//            Memory reads are issued in order.  Reads in flight plus buffered
//            entries never exceed FIFO_DEPTH, so the output buffer cannot
//            overflow.
// Ports    : clk, reset              - clock, synchronous active-high reset
//            start, abort            - one-cycle control pulses
//            sampleNum_Begin/Trig    - first and trigger sample numbers
//            sampleCount             - samples to read (clamped to capacity)
//            rd_req/rd_addr/rd_ack   - memory read request channel
//            rd_data_valid/rd_data   - in-order memory read responses
//            out_valid/out_ready     - decoded sample stream handshake
//            out_data/out_interval   - channel data / transition interval
//            out_trigger/out_last    - trigger sample / final sample flags
//            busy, done              - status; done pulses on completion
// Revision : 1.0 - initial release
// ============================================================================
module sample_readback #(
    parameter int SAMPLE_WIDTH        = 16,
    parameter int SAMPLE_PACKET_WIDTH = 32,
    parameter int MEMORY_CAPACITY     = 2**27,
    parameter int MEMORY_WORD_WIDTH   = 2,
    parameter int FIFO_DEPTH          = 4
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      start,
    input  logic                                      abort,
    input  logic [31:0]                               sampleNum_Begin,
    input  logic [31:0]                               sampleNum_Trig,
    input  logic [31:0]                               sampleCount,
    output logic                                      rd_req,
    output logic [31:0]                               rd_addr,
    input  logic                                      rd_ack,
    input  logic                                      rd_data_valid,
    input  logic [SAMPLE_PACKET_WIDTH-1:0]            rd_data,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic [SAMPLE_WIDTH-1:0]                   out_data,
    output logic [SAMPLE_PACKET_WIDTH-SAMPLE_WIDTH-1:0] out_interval,
    output logic                                      out_trigger,
    output logic                                      out_last,
    output logic                                      busy,
    output logic                                      done
);

    localparam int C_WORDS_PER_PACKET = (SAMPLE_PACKET_WIDTH / 8) / MEMORY_WORD_WIDTH;
    localparam logic [31:0] C_MAX_SAMPLE_NUMBER =
        32'((MEMORY_CAPACITY / MEMORY_WORD_WIDTH) / C_WORDS_PER_PACKET - 1);
    localparam logic [31:0] C_MAX_COUNT = C_MAX_SAMPLE_NUMBER + 32'd1;
    localparam int C_PTR_W   = $clog2(FIFO_DEPTH);
    localparam int C_CNT_W   = C_PTR_W + 1;
    localparam int C_ENTRY_W = SAMPLE_PACKET_WIDTH + 2;
    localparam logic [C_CNT_W:0] C_DEPTH_EXT = (C_CNT_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WAIT  = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [31:0]          count_q, count_d;
    logic [31:0]          trig_q, trig_d;
    logic [31:0]          issued_q, issued_d;
    logic [31:0]          req_addr_q, req_addr_d;
    logic [31:0]          resp_addr_q, resp_addr_d;
    logic [31:0]          resp_idx_q, resp_idx_d;
    logic [C_CNT_W-1:0]   in_flight_q, in_flight_d;
    logic [C_CNT_W-1:0]   occ_q, occ_d;
    logic [C_PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [C_PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic                 done_q, done_d;
    logic [C_ENTRY_W-1:0] fifo_mem_q [FIFO_DEPTH];
    logic [C_ENTRY_W-1:0] fifo_mem_d [FIFO_DEPTH];

    logic                 w_credit;
    logic                 w_ack_fire;
    logic                 w_resp_ok;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_abort_hit;
    logic [31:0]          w_count_clamped;
    logic [C_ENTRY_W-1:0] w_head;
    logic [C_ENTRY_W-1:0] w_push_entry;

    // Ring-buffer successor of a sample number.
    function automatic logic [31:0] next_addr(input logic [31:0] a);
        return (a == C_MAX_SAMPLE_NUMBER) ? 32'd0 : a + 32'd1;
    endfunction

    // A request may only go out while a buffer slot is reserved for its
    // response, counting both reads in flight and entries not yet consumed.
    assign w_credit   = ({1'b0, in_flight_q} + {1'b0, occ_q}) < C_DEPTH_EXT;
    assign rd_req     = (state_q == ST_READ) && (issued_q < count_q) && w_credit;
    assign rd_addr    = req_addr_q;
    assign w_ack_fire = rd_req && rd_ack;

    // Responses with nothing outstanding (protocol violation, or stale after
    // reset) are dropped without touching any counter.
    assign w_resp_ok    = rd_data_valid && (in_flight_q != '0);
    assign w_push       = w_resp_ok && ((state_q == ST_READ) || (state_q == ST_WAIT));
    assign w_push_entry = {rd_data,
                           (resp_addr_q == trig_q),
                           (resp_idx_q == (count_q - 32'd1))};

    assign w_abort_hit     = abort && ((state_q == ST_READ) || (state_q == ST_WAIT));
    assign w_count_clamped = (sampleCount > C_MAX_COUNT) ? C_MAX_COUNT : sampleCount;

    // Entry layout: {interval, data, trigger, last}.  Outputs are forced to
    // zero whenever the buffer is empty so no stale entry is ever visible.
    assign w_head       = fifo_mem_q[rd_ptr_q];
    assign out_valid    = (occ_q != '0);
    assign w_pop        = out_valid && out_ready;
    assign out_last     = out_valid && w_head[0];
    assign out_trigger  = out_valid && w_head[1];
    assign out_data     = out_valid ? w_head[SAMPLE_WIDTH+1:2] : '0;
    assign out_interval = out_valid ? w_head[C_ENTRY_W-1:SAMPLE_WIDTH+2] : '0;
    assign busy         = (state_q != ST_IDLE);
    assign done         = done_q;

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        trig_d      = trig_q;
        issued_d    = issued_q;
        req_addr_d  = req_addr_q;
        resp_addr_d = resp_addr_q;
        resp_idx_d  = resp_idx_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        fifo_mem_d  = fifo_mem_q;
        done_d      = 1'b0;

        in_flight_d = in_flight_q + {{(C_CNT_W-1){1'b0}}, w_ack_fire}
                                  - {{(C_CNT_W-1){1'b0}}, w_resp_ok};
        occ_d       = occ_q + {{(C_CNT_W-1){1'b0}}, w_push}
                            - {{(C_CNT_W-1){1'b0}}, w_pop};

        if (w_resp_ok) begin
            resp_addr_d = next_addr(resp_addr_q);
            resp_idx_d  = resp_idx_q + 32'd1;
        end
        if (w_push) begin
            fifo_mem_d[wr_ptr_q] = w_push_entry;
            wr_ptr_d             = wr_ptr_q + C_PTR_W'(1);
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + C_PTR_W'(1);
        end
        if (w_ack_fire) begin
            issued_d   = issued_q + 32'd1;
            req_addr_d = next_addr(req_addr_q);
        end

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    count_d     = w_count_clamped;
                    trig_d      = sampleNum_Trig;
                    issued_d    = '0;
                    req_addr_d  = sampleNum_Begin;
                    resp_addr_d = sampleNum_Begin;
                    resp_idx_d  = '0;
                    in_flight_d = '0;
                    occ_d       = '0;
                    wr_ptr_d    = '0;
                    rd_ptr_d    = '0;
                    if (w_count_clamped == 32'd0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ST_READ;
                    end
                end
            end
            ST_READ: begin
                if (issued_d == count_q) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (w_pop && w_head[0]) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            ST_FLUSH: begin
                if (in_flight_d == '0) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort empties the buffer immediately; outstanding responses are
        // then absorbed in FLUSH so they cannot leak into a later readback.
        if (w_abort_hit) begin
            state_d  = ST_FLUSH;
            occ_d    = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            done_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            trig_q      <= '0;
            issued_q    <= '0;
            req_addr_q  <= '0;
            resp_addr_q <= '0;
            resp_idx_q  <= '0;
            in_flight_q <= '0;
            occ_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            trig_q      <= trig_d;
            issued_q    <= issued_d;
            req_addr_q  <= req_addr_d;
            resp_addr_q <= resp_addr_d;
            resp_idx_q  <= resp_idx_d;
            in_flight_q <= in_flight_d;
            occ_q       <= occ_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            done_q      <= done_d;
        end
    end

    // Buffer storage needs no reset: occupancy gates every read of it.
    always_ff @(posedge clk) begin
        fifo_mem_q <= fifo_mem_d;
    end

endmodule
`default_nettype wire

// File: tb/tb_sample_readback.sv
`default_nettype none
// ============================================================================
// Module   : tb_sample_readback
// Purpose  : Self-checking bench for sample_readback.  A behavioural memory
//            with configurable latency answers read requests; expected output
//            streams are computed from begin/count/trigger with plain
//            modular arithmetic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sample_readback;

    localparam int SW    = 16;
    localparam int PW    = 32;
    localparam int CAP   = 256;
    localparam int WW    = 2;
    localparam int DEPTH = 4;
    localparam int MAXN  = (CAP / WW) / ((PW / 8) / WW) - 1;

    logic          clk = 1'b0;
    logic          reset, start, abort;
    logic [31:0]   sampleNum_Begin, sampleNum_Trig, sampleCount;
    logic          rd_req, rd_ack, rd_data_valid;
    logic [31:0]   rd_addr;
    logic [PW-1:0] rd_data;
    logic          out_valid, out_ready, out_trigger, out_last, busy, done;
    logic [SW-1:0] out_data;
    logic [PW-SW-1:0] out_interval;

    sample_readback #(
        .SAMPLE_WIDTH(SW), .SAMPLE_PACKET_WIDTH(PW), .MEMORY_CAPACITY(CAP),
        .MEMORY_WORD_WIDTH(WW), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .sampleNum_Begin(sampleNum_Begin), .sampleNum_Trig(sampleNum_Trig),
        .sampleCount(sampleCount), .rd_req(rd_req), .rd_addr(rd_addr),
        .rd_ack(rd_ack), .rd_data_valid(rd_data_valid), .rd_data(rd_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_interval(out_interval), .out_trigger(out_trigger),
        .out_last(out_last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // environment knobs
    int          cyc = 0;
    int          mem_lat = 1, ack_pct = 100, ready_pct = 100, pkt_mode = 0;
    logic [31:0] salt = 32'h0;

    // memory model and observation logs
    logic [31:0] pend_addr[$];
    int          pend_due[$];
    logic [31:0] req_log[$];
    logic [33:0] got[$];
    logic [33:0] exp_q[$];
    logic [31:0] exp_addr[$];
    int          done_log[$];
    int          first_req_cyc, first_ov_cyc, last_hs_cyc, start_cyc;
    int          acks_total, pops_total, max_out, stall_viol;
    bit          busy_seen, ov_seen, busy_at_done, prev_stall;
    logic [33:0] prev_out;

    function automatic logic [31:0] pkt(input logic [31:0] a);
        if (pkt_mode == 0) return a;
        return (a * 32'h9E37_79B1) ^ salt;
    endfunction

    // Expected stream: sample i lives at (begin + i) mod (MAXN + 1).
    function automatic void build_expected(input logic [31:0] b, input logic [31:0] cnt,
                                           input logic [31:0] trg);
        longint n;
        logic [31:0] a, p;
        exp_q.delete();
        exp_addr.delete();
        n = ({32'd0, cnt} > longint'(MAXN + 1)) ? longint'(MAXN + 1) : longint'({32'd0, cnt});
        for (longint i = 0; i < n; i++) begin
            a = 32'((longint'({32'd0, b}) + i) % longint'(MAXN + 1));
            p = pkt(a);
            exp_addr.push_back(a);
            exp_q.push_back({p[31:16], p[15:0], (a == trg), (i == n - 1)});
        end
    endfunction

    task automatic clear_logs();
        got.delete(); req_log.delete(); done_log.delete();
        first_req_cyc = -1; first_ov_cyc = -1; last_hs_cyc = -1;
        acks_total = 0; pops_total = 0; max_out = 0; stall_viol = 0;
        busy_seen = 0; ov_seen = 0; busy_at_done = 0; prev_stall = 0;
    endtask

    // One clock cycle: observe settled outputs at the falling edge, then
    // drive memory and consumer inputs for the next rising edge.
    task automatic step();
        bit dis;
        logic [33:0] cur;
        dis = abort || reset;
        @(negedge clk);
        cyc++;
        cur = {out_interval, out_data, out_trigger, out_last};
        if (prev_stall && !dis && (!out_valid || cur != prev_out)) stall_viol++;
        if (done) begin done_log.push_back(cyc); busy_at_done = busy; end
        if (busy) busy_seen = 1;
        if (out_valid) ov_seen = 1;
        if (rd_req && first_req_cyc < 0) first_req_cyc = cyc;
        if (out_valid && first_ov_cyc < 0) first_ov_cyc = cyc;
        rd_ack = (int'($urandom_range(99)) < ack_pct);
        if (rd_req && rd_ack) begin
            req_log.push_back(rd_addr);
            pend_addr.push_back(rd_addr);
            pend_due.push_back(cyc + mem_lat);
            acks_total++;
        end
        rd_data_valid = 1'b0;
        rd_data       = '0;
        if (pend_due.size() != 0 && pend_due[0] <= cyc) begin
            rd_data_valid = 1'b1;
            rd_data       = pkt(pend_addr.pop_front());
            void'(pend_due.pop_front());
        end
        out_ready = (int'($urandom_range(99)) < ready_pct);
        if (out_valid && out_ready) begin
            got.push_back(cur);
            last_hs_cyc = cyc;
            pops_total++;
        end
        if (acks_total - pops_total > max_out) max_out = acks_total - pops_total;
        prev_stall = out_valid && !out_ready;
        prev_out   = cur;
    endtask

    task automatic run_txn(input logic [31:0] b, input logic [31:0] cnt, input logic [31:0] trg,
                           input int budget, output bit timeout);
        int n;
        clear_logs();
        build_expected(b, cnt, trg);
        sampleNum_Begin = b; sampleNum_Trig = trg; sampleCount = cnt;
        start = 1'b1; start_cyc = cyc;
        step();
        start = 1'b0;
        n = 0;
        while (done_log.size() == 0 && n < budget) begin step(); n++; end
        timeout = (done_log.size() == 0);
        repeat (3) step();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) step();
        reset = 1'b0;
        step();
        checks++; if (rd_req !== 1'b0) begin errors++; $display("FAIL reset_rd_req: got %b expected 0", rd_req); end
        checks++; if (rd_addr !== 32'd0) begin errors++; $display("FAIL reset_rd_addr: got %h expected 0", rd_addr); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if ({out_interval, out_data, out_trigger, out_last} !== 34'd0) begin
            errors++; $display("FAIL reset_out_fields: got %h expected 0", {out_interval, out_data, out_trigger, out_last}); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    endtask

    task automatic test_basic();
        bit to;
        pkt_mode = 0; mem_lat = 1; ack_pct = 100; ready_pct = 100;
        run_txn(32'd10, 32'd5, 32'd12, 100, to);
        checks++; if (to) begin errors++; $display("FAIL basic_timeout: got no done expected done"); end
        checks++; if (first_req_cyc - start_cyc !== 1) begin
            errors++; $display("FAIL basic_req_latency: got %0d expected 1", first_req_cyc - start_cyc); end
        checks++; if (first_ov_cyc - start_cyc !== 3) begin
            errors++; $display("FAIL basic_out_latency: got %0d expected 3", first_ov_cyc - start_cyc); end
        checks++; if (req_log.size() != exp_addr.size()) begin
            errors++; $display("FAIL basic_req_count: got %0d expected %0d", req_log.size(), exp_addr.size()); end
        for (int i = 0; i < req_log.size() && i < exp_addr.size(); i++) begin
            checks++; if (req_log[i] !== exp_addr[i]) begin
                errors++; $display("FAIL basic_rd_addr[%0d]: got %0d expected %0d", i, req_log[i], exp_addr[i]); end
        end
        checks++; if (got.size() != exp_q.size()) begin
            errors++; $display("FAIL basic_out_count: got %0d expected %0d", got.size(), exp_q.size()); end
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            checks++; if (got[i] !== exp_q[i]) begin
                errors++; $display("FAIL basic_out[%0d]: got %h expected %h", i, got[i], exp_q[i]); end
        end
        checks++; if (done_log.size() != 1 || done_log[0] != last_hs_cyc + 1) begin
            errors++; $display("FAIL basic_done_timing: got %0d pulses first at %0d expected 1 at %0d",
                               done_log.size(), (done_log.size() != 0) ? done_log[0] : -1, last_hs_cyc + 1); end
        checks++; if (busy_at_done !== 1'b0) begin errors++; $display("FAIL basic_busy_at_done: got 1 expected 0"); end
    endtask

    task automatic test_wrap();
        bit to;
        pkt_mode = 1; salt = $urandom; mem_lat = int'($urandom_range(3, 1));
        ack_pct = 70; ready_pct = 80;
        run_txn(32'(MAXN - 1), 32'd4, 32'(MAXN), 200, to);
        checks++; if (to) begin errors++; $display("FAIL wrap_timeout: got no done expected done"); end
        checks++; if (req_log.size() != 4) begin
            errors++; $display("FAIL wrap_req_count: got %0d expected 4", req_log.size()); end
        for (int i = 0; i < req_log.size() && i < exp_addr.size(); i++) begin
            checks++; if (req_log[i] !== exp_addr[i]) begin
                errors++; $display("FAIL wrap_rd_addr[%0d]: got %0d expected %0d", i, req_log[i], exp_addr[i]); end
        end
        checks++; if (got.size() != exp_q.size()) begin
            errors++; $display("FAIL wrap_out_count: got %0d expected %0d", got.size(), exp_q.size()); end
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            checks++; if (got[i] !== exp_q[i]) begin
                errors++; $display("FAIL wrap_out[%0d]: got %h expected %h", i, got[i], exp_q[i]); end
        end
        checks++; if (stall_viol != 0) begin errors++; $display("FAIL wrap_hold_stable: got %0d violations expected 0", stall_viol); end
    endtask

    task automatic test_backpressure();
        logic [31:0] b;
        int n;
        pkt_mode = 1; salt = $urandom; mem_lat = 2; ack_pct = 100; ready_pct = 0;
        b = 32'($urandom_range(MAXN, 0));
        clear_logs();
        build_expected(b, 32'd12, b + 32'd3);
        sampleNum_Begin = b; sampleNum_Trig = b + 32'd3; sampleCount = 32'd12;
        start = 1'b1; step(); start = 1'b0;
        repeat (20) step();
        checks++; if (req_log.size() > DEPTH) begin
            errors++; $display("FAIL bp_reads_while_stalled: got %0d expected at most %0d", req_log.size(), DEPTH); end
        checks++; if (got.size() != 0) begin errors++; $display("FAIL bp_no_output: got %0d expected 0", got.size()); end
        ready_pct = 100;
        n = 0;
        while (done_log.size() == 0 && n < 200) begin step(); n++; end
        checks++; if (done_log.size() == 0) begin errors++; $display("FAIL bp_timeout: got no done expected done"); end
        checks++; if (got.size() != exp_q.size()) begin
            errors++; $display("FAIL bp_out_count: got %0d expected %0d", got.size(), exp_q.size()); end
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            checks++; if (got[i] !== exp_q[i]) begin
                errors++; $display("FAIL bp_out[%0d]: got %h expected %h", i, got[i], exp_q[i]); end
        end
        checks++; if (max_out > DEPTH) begin errors++; $display("FAIL bp_outstanding: got %0d expected at most %0d", max_out, DEPTH); end
        checks++; if (stall_viol != 0) begin errors++; $display("FAIL bp_hold_stable: got %0d violations expected 0", stall_viol); end
    endtask

    task automatic test_zero_count();
        bit to;
        mem_lat = 1; ack_pct = 100; ready_pct = 100;
        run_txn(32'd7, 32'd0, 32'd7, 10, to);
        checks++; if (done_log.size() != 1 || done_log[0] != start_cyc + 1) begin
            errors++; $display("FAIL zero_done: got %0d pulses first at %0d expected 1 at %0d",
                               done_log.size(), (done_log.size() != 0) ? done_log[0] : -1, start_cyc + 1); end
        checks++; if (busy_seen) begin errors++; $display("FAIL zero_busy: got 1 expected 0"); end
        checks++; if (first_req_cyc != -1) begin errors++; $display("FAIL zero_rd_req: got req at %0d expected none", first_req_cyc); end
    endtask

    task automatic test_clamp();
        bit to;
        pkt_mode = 1; salt = $urandom; mem_lat = 1; ack_pct = 100; ready_pct = 100;
        run_txn(32'(MAXN - 5), 32'hFFFF_FFFF, 32'(MAXN - 3), 1000, to);
        checks++; if (to) begin errors++; $display("FAIL clamp_timeout: got no done expected done"); end
        checks++; if (req_log.size() != MAXN + 1) begin
            errors++; $display("FAIL clamp_req_count: got %0d expected %0d", req_log.size(), MAXN + 1); end
        checks++; if (got.size() != exp_q.size()) begin
            errors++; $display("FAIL clamp_out_count: got %0d expected %0d", got.size(), exp_q.size()); end
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            checks++; if (got[i] !== exp_q[i]) begin
                errors++; $display("FAIL clamp_out[%0d]: got %h expected %h", i, got[i], exp_q[i]); end
        end
    endtask

    task automatic test_abort();
        int n, got_before;
        bit to, busy_fell;
        logic [31:0] b;
        pkt_mode = 1; salt = $urandom; mem_lat = 2; ack_pct = 100; ready_pct = 100;
        clear_logs();
        sampleNum_Begin = 32'd20; sampleNum_Trig = 32'd0; sampleCount = 32'd20;
        start = 1'b1; step(); start = 1'b0;
        n = 0;
        while (acks_total < 3 && n < 20) begin step(); n++; end
        checks++; if (acks_total < 3) begin errors++; $display("FAIL abort_setup: got %0d acks expected 3", acks_total); end
        abort = 1'b1; step(); abort = 1'b0;
        got_before = got.size();
        checks++; if (rd_req !== 1'b0) begin errors++; $display("FAIL abort_rd_req: got %b expected 0", rd_req); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL abort_out_valid: got %b expected 0", out_valid); end
        ov_seen = 0; busy_fell = 0; n = 0;
        while (!busy_fell && n < 20) begin
            step(); n++;
            if (!busy) begin
                busy_fell = 1;
                checks++; if (pend_addr.size() != 0) begin
                    errors++; $display("FAIL abort_busy_early: got %0d responses pending expected 0", pend_addr.size()); end
            end
        end
        checks++; if (!busy_fell) begin errors++; $display("FAIL abort_busy_stuck: got busy=1 expected 0"); end
        checks++; if (done_log.size() != 0) begin errors++; $display("FAIL abort_done: got %0d pulses expected 0", done_log.size()); end
        checks++; if (ov_seen || got.size() != got_before) begin
            errors++; $display("FAIL abort_flush_output: got out_valid=%b expected 0", ov_seen); end
        b = 32'($urandom_range(MAXN, 0));
        run_txn(b, 32'd6, b + 32'd5, 200, to);
        checks++; if (to) begin errors++; $display("FAIL abort_restart_timeout: got no done expected done"); end
        checks++; if (got.size() != exp_q.size()) begin
            errors++; $display("FAIL abort_restart_count: got %0d expected %0d", got.size(), exp_q.size()); end
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            checks++; if (got[i] !== exp_q[i]) begin
                errors++; $display("FAIL abort_restart_out[%0d]: got %h expected %h", i, got[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_mid();
        int n;
        pkt_mode = 1; salt = $urandom; mem_lat = 3; ack_pct = 100; ready_pct = 0;
        clear_logs();
        sampleNum_Begin = 32'd3; sampleNum_Trig = 32'd4; sampleCount = 32'd20;
        start = 1'b1; step(); start = 1'b0;
        n = 0;
        while (acks_total < 4 && n < 20) begin step(); n++; end
        reset = 1'b1; step(); reset = 1'b0;
        checks++; if ({rd_req, rd_addr, out_valid, out_interval, out_data, out_trigger, out_last, busy, done} !== '0) begin
            errors++; $display("FAIL midreset_outputs: got req=%b addr=%h ov=%b busy=%b done=%b expected all 0",
                               rd_req, rd_addr, out_valid, busy, done); end
        ready_pct = 100; ov_seen = 0; busy_seen = 0;
        repeat (10) step();
        checks++; if (pend_addr.size() != 0) begin errors++; $display("FAIL midreset_drain: got %0d pending expected 0", pend_addr.size()); end
        checks++; if (ov_seen || busy_seen) begin
            errors++; $display("FAIL midreset_stale: got out_valid=%b busy=%b expected 0", ov_seen, busy_seen); end
    endtask

    task automatic test_random();
        bit to;
        logic [31:0] b, cnt, trg;
        for (int t = 0; t < 5; t++) begin
            pkt_mode = 1; salt = $urandom; mem_lat = int'($urandom_range(3, 1));
            ack_pct = int'($urandom_range(100, 40)); ready_pct = int'($urandom_range(100, 30));
            b   = 32'($urandom_range(MAXN, 0));
            cnt = 32'($urandom_range(20, 1));
            trg = 32'((longint'(b) + $urandom_range(25, 0)) % (MAXN + 1));
            run_txn(b, cnt, trg, 600, to);
            checks++; if (to) begin errors++; $display("FAIL rand%0d_timeout: got no done expected done", t); end
            checks++; if (got.size() != exp_q.size()) begin
                errors++; $display("FAIL rand%0d_count: got %0d expected %0d", t, got.size(), exp_q.size()); end
            for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
                checks++; if (got[i] !== exp_q[i]) begin
                    errors++; $display("FAIL rand%0d_out[%0d]: got %h expected %h", t, i, got[i], exp_q[i]); end
            end
            checks++; if (max_out > DEPTH || stall_viol != 0) begin
                errors++; $display("FAIL rand%0d_flow: got outstanding %0d hold violations %0d expected <=%0d and 0",
                                   t, max_out, stall_viol, DEPTH); end
            checks++; if (done_log.size() != 1) begin
                errors++; $display("FAIL rand%0d_done_pulses: got %0d expected 1", t, done_log.size()); end
        end
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; abort = 1'b0;
        sampleNum_Begin = '0; sampleNum_Trig = '0; sampleCount = '0;
        rd_ack = 1'b0; rd_data_valid = 1'b0; rd_data = '0; out_ready = 1'b0;
        clear_logs();
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_zero_count();
        test_clamp();
        test_abort();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/sample_readback.md
# sample_readback

Reads a finished capture back out of sample memory and turns each stored sample packet into a decoded output stream for the host upload path. It walks sample numbers from the capture's begin sample to its end sample, wrapping at the top of the ring buffer. It issues in-order memory read requests with bounded outstanding reads, and splits each packet into transition interval and channel data. It also flags the trigger sample and the final sample. It sits between the capture status registers and sample memory on one side and the upload serializer on the other.

## Interface
- SAMPLE_WIDTH, 16, number of data channels in a packet
- SAMPLE_PACKET_WIDTH, 32, stored packet width; upper SAMPLE_PACKET_WIDTH-SAMPLE_WIDTH bits are the interval
- MEMORY_CAPACITY, 2**27, memory size in bytes
- MEMORY_WORD_WIDTH, 2, bytes per memory word
- FIFO_DEPTH, 4, output buffer entries; also bounds in-flight reads (power of 2, ≥2)
- Derived: MAX_SAMPLE_NUMBER = (MEMORY_CAPACITY/MEMORY_WORD_WIDTH)/((SAMPLE_PACKET_WIDTH/8)/MEMORY_WORD_WIDTH) - 1

Ports:
- clk  in  1  sole clock
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle pulse; begins readback (ignored unless idle)
- abort  in  1  one-cycle pulse; terminates readback
- sampleNum_Begin  in  32  first sample number to read
- sampleNum_Trig  in  32  sample number of the trigger sample
- sampleCount  in  32  number of samples to read
- rd_req  out  1  memory read request
- rd_addr  out  32  sample number requested
- rd_ack  in  1  request accepted this cycle
- rd_data_valid  in  1  read response valid (in request order, latency ≥1)
- rd_data  in  SAMPLE_PACKET_WIDTH  response packet
- out_valid  out  1  output sample available
- out_ready  in  1  consumer accepts
- out_data  out  SAMPLE_WIDTH  channel data
- out_interval  out  SAMPLE_PACKET_WIDTH-SAMPLE_WIDTH  sample clocks since previous transition
- out_trigger  out  1  this sample is the trigger sample
- out_last  out  1  final sample of the readback
- busy  out  1  readback in progress
- done  out  1  one-cycle pulse at normal completion

## Operation
- States:
  - IDLE: waits for start.
  - READ: issues requests.
  - WAIT: all requests issued; waits for responses and FIFO drain.
  - FLUSH: after abort, discards in-flight responses.
- On start in IDLE:
  - Latch begin, trig and count. Count is clamped to MAX_SAMPLE_NUMBER+1.
  - Clear all counters.
  - Go to READ if count ≠ 0. Otherwise pulse done next cycle and stay IDLE.
- READ:
  - rd_req=1 while issued < count and (in_flight + fifo_occupancy) < FIFO_DEPTH.
  - rd_addr starts at begin.
  - On rd_ack: next address = (addr == MAX_SAMPLE_NUMBER) ? 0 : addr+1.
  - Issued increments on rd_ack.
  - Go to WAIT when issued reaches count.
- Each rd_data_valid pushes {interval=rd_data[MSBs], data=rd_data[SAMPLE_WIDTH-1:0], trigger, last} into the FIFO:
  - trigger = (address of that response == trig).
  - last = (response index == count-1).
  - The response address is tracked by a separate wrapping counter in the same manner as rd_addr.
- The credit rule guarantees the FIFO never overflows. A response arriving when no read is in flight is a protocol violation; it is ignored and not pushed.
- WAIT → IDLE when the out_last sample handshakes (out_valid & out_ready). done pulses on that same transition.
- Abort from READ or WAIT:
  - rd_req deasserts next cycle.
  - FIFO is cleared; out_valid drops next cycle.
  - Go to FLUSH until in_flight == 0 (responses discarded), then IDLE.
  - No done pulse.
  - Abort in IDLE is ignored.
- busy = (state ≠ IDLE).
- Simultaneous start and abort in IDLE: start wins.
- Simultaneous push and pop: occupancy unchanged.
- out_* held stable while out_valid & !out_ready.

## Timing
- Reset values: rd_req=0, rd_addr=0, out_valid=0, out_data=0, out_interval=0, out_trigger=0, out_last=0, busy=0, done=0. FIFO and all counters are cleared.
- Reset mid-readback returns to IDLE immediately. Later responses are ignored (in_flight=0).
- rd_req is first asserted the cycle after start.
- rd_addr is held constant while rd_req & !rd_ack.
- One request per cycle maximum. Back-to-back acks sustain 1 read/cycle when out_ready=1 and the FIFO is not full.
- A response becomes visible on out_valid the cycle after rd_data_valid. Minimum start-to-out_valid latency is 3 cycles with rd_ack same cycle and 1-cycle memory latency.
- done is registered and asserted the cycle after the final handshake. busy falls in that same cycle.
- in_flight is updated as +rd_ack −rd_data_valid each cycle.

## Test plan
- begin=10, count=5, trig=12, memory returns packet = addr → rd_addr 10..14, out_data=10..14, out_trigger only on 12, out_last on 14, done one cycle after last handshake.
- Wrap: begin=MAX_SAMPLE_NUMBER-1, count=4 → rd_addr sequence MAX-1, MAX, 0, 1. out_interval equals the packet upper half unmodified.
- Backpressure: out_ready=0 for 20 cycles with 2-cycle memory latency → at most FIFO_DEPTH reads issued, no sample lost or duplicated, order preserved when ready returns.
- count=0 → no rd_req, done pulses the cycle after start, busy never set. count=2**32-1 → clamped to MAX_SAMPLE_NUMBER+1 reads.
- Abort after 3 acks with 2 responses pending → rd_req low next cycle, out_valid low next cycle, busy low after the pending responses arrive, no done. A following start reads correctly from the new begin.
- Reset asserted mid-READ → all outputs at reset values the next cycle. A stale rd_data_valid is not output.
